axi4_slave_write_responder: RTL and testbench

- Synthesizable AXI4 slave-side write responder: the target end of the write address (AW), write data (W) and write response (B) channels that the master agent drives.
- Accepts one write burst at a time into an internal byte-addressed memory and returns a B response with the captured ID.
- Used as the RTL DUT/target behind the slave interface, and as the golden slave for master-agent regressions.

---
 rtl/axi4_slave_write_responder.sv | 198 +++++++++++++++++++
 tb/tb_axi4_slave_write_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_write_responder.sv
// AXI4 slave write responder: single-burst AW/W/B target backed by a byte memory.
// Optional macro AXI4_SLAVE_B_WAIT_EN adds a programmable delay before bvalid.
module axi4_slave_write_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 4,
  parameter int MEM_BYTES     = 4096
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [ID_WIDTH-1:0]       awid,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [ID_WIDTH-1:0]       bid,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
`ifdef AXI4_SLAVE_B_WAIT_EN
  input  logic [3:0]                b_wait_cycles,
`endif
  input  logic [ADDRESS_WIDTH-1:0]  dbg_addr,
  output logic [7:0]                dbg_rdata
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LANE_BITS  = $clog2(STRB_WIDTH);
  localparam int MEM_AW     = $clog2(MEM_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] MEM_LIMIT = ADDRESS_WIDTH'(MEM_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] LANE_MASK = ADDRESS_WIDTH'(STRB_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                     state_reg, state_next;
  logic [ID_WIDTH-1:0]        id_reg, id_next;
  logic [ADDRESS_WIDTH-1:0]   start_reg, start_next;
  logic [ADDRESS_WIDTH-1:0]   cur_addr_reg, cur_addr_next;
  logic [7:0]                 len_reg, len_next;
  logic [2:0]                 size_reg, size_next;
  logic [1:0]                 burst_reg, burst_next;
  logic [7:0]                 beat_cnt_reg, beat_cnt_next;
  logic                       addr_err_reg, addr_err_next;
  logic                       slverr_reg, slverr_next;
  logic                       decerr_reg, decerr_next;
  logic                       awready_next, wready_next, bvalid_next;
  logic [ID_WIDTH-1:0]        bid_next;
  logic [1:0]                 bresp_next;
  logic [3:0]                 wait_cnt_reg, wait_cnt_next;

  logic [7:0]                 mem [MEM_BYTES];
  logic [ADDRESS_WIDTH-1:0]   lane_addr [STRB_WIDTH];
  logic [STRB_WIDTH-1:0]      lane_oor;
  logic [ADDRESS_WIDTH-1:0]   size_bytes, wrap_bytes, wrap_base, beat_base;
  logic [ADDRESS_WIDTH-1:0]   incr_addr, wrap_addr;
  logic                       beat_fire, beat_oor, mem_we, last_beat, aw_err;

  assign size_bytes = ADDRESS_WIDTH'(1) << size_reg;
  assign wrap_bytes = (ADDRESS_WIDTH'(len_reg) + ADDRESS_WIDTH'(1)) << size_reg;
  assign wrap_base  = start_reg & ~(wrap_bytes - ADDRESS_WIDTH'(1));
  assign beat_base  = cur_addr_reg & ~LANE_MASK;
  assign incr_addr  = (cur_addr_reg & ~(size_bytes - ADDRESS_WIDTH'(1))) + size_bytes;
  assign wrap_addr  = (incr_addr == wrap_base + wrap_bytes) ? wrap_base : incr_addr;

  // Per-lane byte addresses; a strobed lane beyond the memory drops the whole beat.
  generate
    for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
      assign lane_addr[gi] = beat_base + ADDRESS_WIDTH'(gi);
      assign lane_oor[gi]  = wstrb[gi] && (lane_addr[gi] >= MEM_LIMIT);
    end
  endgenerate

  assign beat_fire = wvalid && wready;
  assign beat_oor  = |lane_oor;
  assign mem_we    = beat_fire && !addr_err_reg && !beat_oor;
  assign last_beat = (beat_cnt_reg == len_reg);
  assign aw_err    = (awburst == 2'b11) || (awsize > 3'(LANE_BITS)) ||
                     ((awburst == 2'b10) && !((awlen == 8'd1) || (awlen == 8'd3) ||
                                              (awlen == 8'd7) || (awlen == 8'd15)));

  always_comb begin
    state_next    = state_reg;
    id_next       = id_reg;
    start_next    = start_reg;
    cur_addr_next = cur_addr_reg;
    len_next      = len_reg;
    size_next     = size_reg;
    burst_next    = burst_reg;
    beat_cnt_next = beat_cnt_reg;
    addr_err_next = addr_err_reg;
    slverr_next   = slverr_reg;
    decerr_next   = decerr_reg;
    bid_next      = bid;
    bresp_next    = bresp;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (awvalid && awready) begin
          id_next       = awid;
          start_next    = awaddr;
          cur_addr_next = awaddr;
          len_next      = awlen;
          size_next     = awsize;
          burst_next    = awburst;
          beat_cnt_next = 8'd0;
          addr_err_next = aw_err;
          slverr_next   = aw_err;
          decerr_next   = 1'b0;
          state_next    = DATA;
        end
      end
      DATA: begin
        if (beat_fire) begin
          if (beat_oor) decerr_next = 1'b1;
          if (wlast != last_beat) slverr_next = 1'b1;
          beat_cnt_next = beat_cnt_reg + 8'd1;
          case (burst_reg)
            2'b00:   cur_addr_next = cur_addr_reg;
            2'b10:   cur_addr_next = wrap_addr;
            default: cur_addr_next = incr_addr;
          endcase
          if (last_beat) begin
            state_next = RESP;
            bid_next   = id_reg;
            bresp_next = decerr_next ? 2'b11 : (slverr_next ? 2'b10 : 2'b00);
`ifdef AXI4_SLAVE_B_WAIT_EN
            wait_cnt_next = b_wait_cycles;
`endif
          end
        end
      end
      RESP: begin
        if (bvalid && bready) state_next = IDLE;
        else if (!bvalid && wait_cnt_reg != 4'd0) wait_cnt_next = wait_cnt_reg - 4'd1;
      end
      default: state_next = IDLE;
    endcase
    awready_next = (state_next == IDLE);
    wready_next  = (state_next == DATA);
    bvalid_next  = (state_next == RESP) && (wait_cnt_next == 4'd0);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg    <= IDLE;
      id_reg       <= '0;
      start_reg    <= '0;
      cur_addr_reg <= '0;
      len_reg      <= '0;
      size_reg     <= '0;
      burst_reg    <= '0;
      beat_cnt_reg <= '0;
      addr_err_reg <= 1'b0;
      slverr_reg   <= 1'b0;
      decerr_reg   <= 1'b0;
      wait_cnt_reg <= '0;
      awready      <= 1'b0;
      wready       <= 1'b0;
      bvalid       <= 1'b0;
      bid          <= '0;
      bresp        <= '0;
    end else begin
      state_reg    <= state_next;
      id_reg       <= id_next;
      start_reg    <= start_next;
      cur_addr_reg <= cur_addr_next;
      len_reg      <= len_next;
      size_reg     <= size_next;
      burst_reg    <= burst_next;
      beat_cnt_reg <= beat_cnt_next;
      addr_err_reg <= addr_err_next;
      slverr_reg   <= slverr_next;
      decerr_reg   <= decerr_next;
      wait_cnt_reg <= wait_cnt_next;
      awready      <= awready_next;
      wready       <= wready_next;
      bvalid       <= bvalid_next;
      bid          <= bid_next;
      bresp        <= bresp_next;
    end
  end

  // Memory has no reset so contents survive an aborted burst.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (mem_we && wstrb[i]) mem[lane_addr[i][MEM_AW-1:0]] <= wdata[8*i +: 8];
    end
  end

  assign dbg_rdata = (dbg_addr < MEM_LIMIT) ? mem[dbg_addr[MEM_AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// Directed and randomized bench for axi4_slave_write_responder against a byte-array model.
module tb_axi4_slave_write_responder;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int MB = 4096;
  localparam int SB = DW / 8;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [IW-1:0] awid = '0;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic [2:0]    awsize = '0;
  logic [1:0]    awburst = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [SB-1:0] wstrb = '0;
  logic          wlast = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [7:0]    dbg_rdata;

  always #5 aclk = ~aclk;

  axi4_slave_write_responder #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_BYTES(MB)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]    ref_mem   [MB];
  bit            ref_known [MB];
  logic [DW-1:0] bdata [16];
  logic [SB-1:0] bstrb [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic bit addr_error(input int len, input int size, input int burst);
    return (burst == 3) || (size > 2) ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // Beat k start address from the burst rules, in plain modular arithmetic.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                            input int size, input int burst, input int k);
    logic [31:0] sz, a, total, base;
    sz = 32'd1 << size;
    a  = start;
    if (burst == 0) return start;
    if (burst == 1) begin
      for (int j = 0; j < k; j++) a = a - (a % sz) + sz;
      return a;
    end
    total = 32'(len + 1) * sz;
    base  = start - (start % total);
    return base + (((start - base) + 32'(k) * sz) % total);
  endfunction

  task automatic model_beat(input logic [31:0] a, input logic [DW-1:0] d, input logic [SB-1:0] s,
                            input bit aerr, output bit oor);
    logic [31:0] base;
    base = a - (a % SB);
    oor  = 1'b0;
    for (int i = 0; i < SB; i++) if (s[i] && (base + 32'(i)) >= MB) oor = 1'b1;
    if (!oor && !aerr) begin
      for (int i = 0; i < SB; i++) begin
        if (s[i]) begin
          ref_mem[base + 32'(i)]   = d[8*i +: 8];
          ref_known[base + 32'(i)] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_window(input logic [31:0] start, input int len, input int size, input int burst);
    logic [31:0] base, p;
    for (int k = 0; k <= len; k++) begin
      base = beat_addr(start, len, size, burst, k);
      base = base - (base % SB);
      for (int i = 0; i < SB; i++) begin
        p = base + 32'(i);
        if (p < MB && ref_known[p]) begin
          dbg_addr = p;
          #1;
          chk("dbg_byte", {56'd0, dbg_rdata}, {56'd0, ref_mem[p]});
        end
      end
    end
  endtask

  task automatic aw_handshake(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
    int t;
    t = 0;
    while (awready !== 1'b1 && t < 64) begin tick(); t++; end
    chk("aw_ready_wait", {63'd0, awready}, 64'd1);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("aw_accept_awready", {63'd0, awready}, 64'd0);
    chk("aw_accept_wready", {63'd0, wready}, 64'd1);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [SB-1:0] s, input logic last);
    int t;
    bit ok;
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    t = 0;
    ok = 1'b0;
    while (!ok && t < 64) begin
      ok = (wready === 1'b1);
      tick();
      t++;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk("w_handshake", {63'd0, ok}, 64'd1);
  endtask

  task automatic run_burst(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int wlast_at, input bit gaps,
                           input int bready_delay, output logic [1:0] resp_obs);
    bit aerr, dec, slv, oor;
    logic [1:0] exp_resp;
    aerr = addr_error(len, size, burst);
    dec  = 1'b0;
    slv  = aerr;
    aw_handshake(id, addr, 8'(len), 3'(size), 2'(burst));
    for (int k = 0; k <= len; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_beat(bdata[k], bstrb[k], k == wlast_at);
      model_beat(beat_addr(addr, len, size, burst, k), bdata[k], bstrb[k], aerr, oor);
      if (oor) dec = 1'b1;
      if ((k == len) != (k == wlast_at)) slv = 1'b1;
    end
    exp_resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    chk("b_latency_bvalid", {63'd0, bvalid}, 64'd1);
    chk("b_latency_wready", {63'd0, wready}, 64'd0);
    repeat (bready_delay) begin
      tick();
      chk("b_hold_bvalid", {63'd0, bvalid}, 64'd1);
      chk("b_hold_bid", {60'd0, bid}, {60'd0, id});
      chk("b_hold_bresp", {62'd0, bresp}, {62'd0, exp_resp});
    end
    resp_obs = bresp;
    chk("b_bid", {60'd0, bid}, {60'd0, id});
    chk("b_bresp", {62'd0, bresp}, {62'd0, exp_resp});
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("b_done_bvalid", {63'd0, bvalid}, 64'd0);
    chk("b_done_awready", {63'd0, awready}, 64'd1);
    check_window(addr, len, size, burst);
    $display("burst id=%0h addr=%0h len=%0d size=%0d type=%0d resp=%0d", id, addr, len, size, burst, resp_obs);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] r;
    logic [31:0] a;
    int len, size, burst, wl;
    bit oor;
    int wrap_lens [4];
    wrap_lens[0] = 1; wrap_lens[1] = 3; wrap_lens[2] = 7; wrap_lens[3] = 15;

    // Reset state
    repeat (3) tick();
    chk("rst_awready", {63'd0, awready}, 64'd0);
    chk("rst_wready", {63'd0, wready}, 64'd0);
    chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
    chk("rst_bid", {60'd0, bid}, 64'd0);
    chk("rst_bresp", {62'd0, bresp}, 64'd0);
    areset = 1'b0;
    chk("rst_release_awready_low", {63'd0, awready}, 64'd0);
    tick();
    chk("rst_release_awready_high", {63'd0, awready}, 64'd1);

    // INCR burst at 0x100
    bdata[0] = 32'h11223344; bdata[1] = 32'h22334455; bdata[2] = 32'h33445566; bdata[3] = 32'h44556677;
    for (int k = 0; k < 4; k++) bstrb[k] = 4'hF;
    run_burst(4'd5, 32'h100, 3, 2, 1, 3, 1'b0, 0, r);
    chk("incr_bresp_okay", {62'd0, r}, 64'd0);
    dbg_addr = 32'h100; #1; chk("incr_dbg_100", {56'd0, dbg_rdata}, 64'h44);
    dbg_addr = 32'h10F; #1; chk("incr_dbg_10f", {56'd0, dbg_rdata}, 64'h44);

    // WRAP burst at 0x38, then an illegal WRAP length over the same bytes
    for (int k = 0; k < 4; k++) bdata[k] = 32'h01010101 * 32'(k + 1);
    run_burst(4'd3, 32'h38, 3, 2, 2, 3, 1'b0, 0, r);
    chk("wrap_bresp_okay", {62'd0, r}, 64'd0);
    dbg_addr = 32'h30; #1; chk("wrap_dbg_30", {56'd0, dbg_rdata}, 64'h03);
    dbg_addr = 32'h3C; #1; chk("wrap_dbg_3c", {56'd0, dbg_rdata}, 64'h02);
    for (int k = 0; k < 3; k++) bdata[k] = 32'hEEEEEEEE;
    run_burst(4'd9, 32'h38, 2, 2, 2, 2, 1'b0, 0, r);
    chk("wrap_len2_slverr", {62'd0, r}, 64'd2);
    dbg_addr = 32'h38; #1; chk("wrap_len2_no_write", {56'd0, dbg_rdata}, 64'h01);

    // Top-of-memory boundary
    bdata[0] = 32'hCAFEF00D; bdata[1] = 32'h12345678;
    run_burst(4'd1, 32'(MB - 4), 1, 2, 1, 1, 1'b0, 0, r);
    chk("boundary_decerr", {62'd0, r}, 64'd3);
    dbg_addr = 32'(MB - 1); #1; chk("boundary_last_byte", {56'd0, dbg_rdata}, 64'hCA);
    dbg_addr = 32'(MB); #1; chk("dbg_out_of_range", {56'd0, dbg_rdata}, 64'h00);
    dbg_addr = 32'hFFFFF000; #1; chk("dbg_alias_out_of_range", {56'd0, dbg_rdata}, 64'h00);

    // Partial strobes
    bdata[0] = 32'hA1B2C3D4; bstrb[0] = 4'hF;
    run_burst(4'd2, 32'h200, 0, 2, 1, 0, 1'b0, 0, r);
    bdata[0] = 32'h55667788; bstrb[0] = 4'b0101;
    run_burst(4'd2, 32'h200, 0, 2, 1, 0, 1'b0, 0, r);
    dbg_addr = 32'h200; #1; chk("strb_lane0", {56'd0, dbg_rdata}, 64'h88);
    dbg_addr = 32'h201; #1; chk("strb_lane1", {56'd0, dbg_rdata}, 64'hC3);
    dbg_addr = 32'h202; #1; chk("strb_lane2", {56'd0, dbg_rdata}, 64'h66);
    dbg_addr = 32'h203; #1; chk("strb_lane3", {56'd0, dbg_rdata}, 64'hA1);

    // Handshake stress: wvalid gaps, early wlast, slow bready
    for (int k = 0; k < 4; k++) begin bdata[k] = $urandom; bstrb[k] = 4'hF; end
    run_burst(4'd7, 32'h400, 3, 2, 1, 1, 1'b1, 5, r);
    chk("stress_slverr", {62'd0, r}, 64'd2);

    // Reset in the middle of a burst
    aw_handshake(4'd6, 32'h300, 8'd3, 3'd2, 2'd1);
    for (int k = 0; k < 2; k++) begin
      bdata[k] = $urandom;
      send_beat(bdata[k], 4'hF, 1'b0);
      model_beat(beat_addr(32'h300, 3, 2, 1, k), bdata[k], 4'hF, 1'b0, oor);
    end
    areset = 1'b1;
    #1;
    chk("midrst_wready", {63'd0, wready}, 64'd0);
    chk("midrst_bvalid", {63'd0, bvalid}, 64'd0);
    chk("midrst_awready", {63'd0, awready}, 64'd0);
    tick(); tick();
    areset = 1'b0;
    tick();
    chk("midrst_release_awready", {63'd0, awready}, 64'd1);
    chk("midrst_release_bvalid", {63'd0, bvalid}, 64'd0);
    check_window(32'h300, 1, 2, 1);
    $display("burst id=6 addr=300 aborted by reset after 2 beats");

    // Randomized legal bursts
    for (int n = 0; n < 16; n++) begin
      burst = $urandom_range(0, 2);
      size  = $urandom_range(0, 2);
      len   = (burst == 2) ? wrap_lens[$urandom_range(0, 3)] : int'($urandom_range(0, 7));
      a     = ($urandom_range(0, 3) == 0) ? 32'(MB - 16 + $urandom_range(0, 15))
                                          : 32'($urandom_range(0, MB - 1));
      a     = a & ~((32'd1 << size) - 32'd1);
      wl    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : len;
      for (int k = 0; k <= len; k++) begin bdata[k] = $urandom; bstrb[k] = 4'($urandom); end
      run_burst(4'($urandom), a, len, size, burst, wl, 1'($urandom), $urandom_range(0, 3), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
